scalar_wb_arbiter: RTL and testbench

- Sits directly downstream of the 2-stage multiplier, the ALU and the iterative divider. Merges their exe_wb_scalar_instr_t results onto the single scalar write-back port.
- The ALU always wins and is never buffered. MUL and DIV results enter per-source FIFOs with a same-cycle bypass when the port is free.
- Raises early stall signals so issue stops sending MUL/DIV before the FIFOs overflow. The multiplier itself cannot stall.

---
 rtl/scalar_wb_arbiter_if.sv | 53 +++++
 rtl/scalar_wb_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_scalar_wb_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/scalar_wb_arbiter_if.sv
// Scalar write-back arbiter: result struct package and bus interface.
// The stats ports exist only when WB_ARB_STATS_EN is defined.

package scalar_wb_pkg;
    typedef struct packed {
        logic        valid;
        logic [1:0]  fu;
        logic [3:0]  rob_id;
        logic [4:0]  rd;
        logic        regfile_we;
        logic [31:0] pc;
        logic [31:0] result;
    } exe_wb_scalar_instr_t;
endpackage

interface scalar_wb_arbiter_if #(
    parameter int MUL_FIFO_DEPTH = 4,
    parameter int DIV_FIFO_DEPTH = 2
);
    import scalar_wb_pkg::*;

    logic                              flush_i;
    exe_wb_scalar_instr_t              alu_instr_i;
    exe_wb_scalar_instr_t              mul_instr_i;
    exe_wb_scalar_instr_t              div_instr_i;
    exe_wb_scalar_instr_t              instruction_o;
    logic                              mul_stall_o;
    logic                              div_stall_o;
    logic [$clog2(MUL_FIFO_DEPTH):0]   mul_cnt_o;
    logic [$clog2(DIV_FIFO_DEPTH):0]   div_cnt_o;
`ifdef WB_ARB_STATS_EN
    logic [31:0]                       conflict_cycles_o;
    logic [$clog2(MUL_FIFO_DEPTH):0]   max_mul_occ_o;
`endif

    // Arbiter side
    modport slave (
        input  flush_i, alu_instr_i, mul_instr_i, div_instr_i,
        output instruction_o, mul_stall_o, div_stall_o, mul_cnt_o, div_cnt_o
`ifdef WB_ARB_STATS_EN
        , output conflict_cycles_o, max_mul_occ_o
`endif
    );

    // Execution-unit / write-back side
    modport master (
        output flush_i, alu_instr_i, mul_instr_i, div_instr_i,
        input  instruction_o, mul_stall_o, div_stall_o, mul_cnt_o, div_cnt_o
`ifdef WB_ARB_STATS_EN
        , input conflict_cycles_o, max_mul_occ_o
`endif
    );
endinterface

// File: rtl/scalar_wb_arbiter.sv
// Scalar write-back arbiter: merges ALU, MUL and DIV results onto one port.
// Fixed priority ALU > MUL FIFO > MUL bypass > DIV FIFO > DIV bypass.
// MUL/DIV results that lose arbitration are buffered in per-source FIFOs.
// Optional statistics outputs are enabled by defining WB_ARB_STATS_EN.

module scalar_wb_arbiter
    import scalar_wb_pkg::*;
#(
    parameter int MUL_FIFO_DEPTH = 4,
    parameter int DIV_FIFO_DEPTH = 2,
    parameter int MUL_INFLIGHT   = 2
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    scalar_wb_arbiter_if.slave   bus
);
    localparam int MPW = $clog2(MUL_FIFO_DEPTH);
    localparam int MCW = MPW + 1;
    localparam int DPW = $clog2(DIV_FIFO_DEPTH);
    localparam int DCW = DPW + 1;

    localparam logic [MPW-1:0] MP_ONE  = 1;
    localparam logic [MCW-1:0] MC_ONE  = 1;
    localparam logic [MCW-1:0] MC_FULL = MCW'(MUL_FIFO_DEPTH);
    localparam logic [DPW-1:0] DP_ONE  = 1;
    localparam logic [DCW-1:0] DC_ONE  = 1;
    localparam logic [DCW-1:0] DC_FULL = DCW'(DIV_FIFO_DEPTH);

    exe_wb_scalar_instr_t r_mul_mem [MUL_FIFO_DEPTH];
    exe_wb_scalar_instr_t r_div_mem [DIV_FIFO_DEPTH];
    logic [MPW-1:0]       r_mul_wr, r_mul_rd;
    logic [DPW-1:0]       r_div_wr, r_div_rd;
    logic [MCW-1:0]       r_mul_cnt;
    logic [DCW-1:0]       r_div_cnt;
    logic                 r_mul_stall, r_div_stall;

    logic                 w_flush;
    logic                 w_alu_v, w_mul_in_v, w_div_in_v;
    logic                 w_mul_head_v, w_div_head_v;
    logic                 w_g_alu, w_g_mul_head, w_g_mul_byp, w_g_div_head, w_g_div_byp;
    logic                 w_mul_push, w_mul_pop, w_mul_full, w_mul_wr_en;
    logic                 w_div_push, w_div_pop, w_div_full, w_div_wr_en;
    logic [MCW-1:0]       w_mul_cnt_nxt;
    logic [DCW-1:0]       w_div_cnt_nxt;
    logic                 w_mul_stall_nxt, w_div_stall_nxt;
    exe_wb_scalar_instr_t w_out;

    // Grant decode, FIFO push/pop qualification and next-state counts
    always_comb begin
        w_flush      = bus.flush_i;
        w_alu_v      = bus.alu_instr_i.valid;
        w_mul_in_v   = bus.mul_instr_i.valid;
        w_div_in_v   = bus.div_instr_i.valid;
        w_mul_head_v = (r_mul_cnt != '0);
        w_div_head_v = (r_div_cnt != '0);

        w_g_alu      = w_alu_v;
        w_g_mul_head = !w_alu_v && w_mul_head_v;
        w_g_mul_byp  = !w_alu_v && !w_mul_head_v && w_mul_in_v;
        w_g_div_head = !w_alu_v && !w_mul_head_v && !w_mul_in_v && w_div_head_v;
        w_g_div_byp  = !w_alu_v && !w_mul_head_v && !w_mul_in_v && !w_div_head_v && w_div_in_v;

        w_mul_full   = (r_mul_cnt == MC_FULL);
        w_mul_pop    = w_g_mul_head && !w_flush;
        w_mul_push   = w_mul_in_v && !w_g_mul_byp && !w_flush;
        // A push into a full FIFO is only legal when the head leaves in the same cycle
        w_mul_wr_en  = w_mul_push && (!w_mul_full || w_mul_pop);

        w_div_full   = (r_div_cnt == DC_FULL);
        w_div_pop    = w_g_div_head && !w_flush;
        w_div_push   = w_div_in_v && !w_g_div_byp && !w_flush;
        w_div_wr_en  = w_div_push && (!w_div_full || w_div_pop);

        w_mul_cnt_nxt = r_mul_cnt;
        if (w_flush)
            w_mul_cnt_nxt = '0;
        else if (w_mul_wr_en && !w_mul_pop)
            w_mul_cnt_nxt = r_mul_cnt + MC_ONE;
        else if (!w_mul_wr_en && w_mul_pop)
            w_mul_cnt_nxt = r_mul_cnt - MC_ONE;

        w_div_cnt_nxt = r_div_cnt;
        if (w_flush)
            w_div_cnt_nxt = '0;
        else if (w_div_wr_en && !w_div_pop)
            w_div_cnt_nxt = r_div_cnt + DC_ONE;
        else if (!w_div_wr_en && w_div_pop)
            w_div_cnt_nxt = r_div_cnt - DC_ONE;

        // Stall early enough to absorb the results still inside the multiplier
        w_mul_stall_nxt = !w_flush && ((int'(w_mul_cnt_nxt) + MUL_INFLIGHT) >= MUL_FIFO_DEPTH);
        w_div_stall_nxt = !w_flush && ((w_div_cnt_nxt != '0) || w_div_in_v);
    end

    // Output mux from the winning source; nothing is granted during a flush
    always_comb begin
        w_out = '0;
        if (!w_flush) begin
            if (w_g_alu)
                w_out = bus.alu_instr_i;
            else if (w_g_mul_head)
                w_out = r_mul_mem[r_mul_rd];
            else if (w_g_mul_byp)
                w_out = bus.mul_instr_i;
            else if (w_g_div_head)
                w_out = r_div_mem[r_div_rd];
            else if (w_g_div_byp)
                w_out = bus.div_instr_i;
        end
    end

    // MUL result FIFO storage, pointers and occupancy
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < MUL_FIFO_DEPTH; i++)
                r_mul_mem[i] <= '0;
            r_mul_wr  <= '0;
            r_mul_rd  <= '0;
            r_mul_cnt <= '0;
        end else if (w_flush) begin
            r_mul_wr  <= '0;
            r_mul_rd  <= '0;
            r_mul_cnt <= '0;
        end else begin
            if (w_mul_wr_en) begin
                r_mul_mem[r_mul_wr] <= bus.mul_instr_i;
                r_mul_wr            <= r_mul_wr + MP_ONE;
            end
            if (w_mul_pop)
                r_mul_rd <= r_mul_rd + MP_ONE;
            r_mul_cnt <= w_mul_cnt_nxt;
        end
    end

    // DIV result FIFO storage, pointers and occupancy
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < DIV_FIFO_DEPTH; i++)
                r_div_mem[i] <= '0;
            r_div_wr  <= '0;
            r_div_rd  <= '0;
            r_div_cnt <= '0;
        end else if (w_flush) begin
            r_div_wr  <= '0;
            r_div_rd  <= '0;
            r_div_cnt <= '0;
        end else begin
            if (w_div_wr_en) begin
                r_div_mem[r_div_wr] <= bus.div_instr_i;
                r_div_wr            <= r_div_wr + DP_ONE;
            end
            if (w_div_pop)
                r_div_rd <= r_div_rd + DP_ONE;
            r_div_cnt <= w_div_cnt_nxt;
        end
    end

    // Registered issue stalls
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_mul_stall <= 1'b0;
            r_div_stall <= 1'b0;
        end else begin
            r_mul_stall <= w_mul_stall_nxt;
            r_div_stall <= w_div_stall_nxt;
        end
    end

    a_mul_no_overflow: assert property (@(posedge clk_i) disable iff (!rstn_i)
        !(w_mul_push && w_mul_full && !w_mul_pop));
    a_div_no_overflow: assert property (@(posedge clk_i) disable iff (!rstn_i)
        !(w_div_push && w_div_full && !w_div_pop));

`ifdef WB_ARB_STATS_EN
    logic [31:0]    r_conflict;
    logic [MCW-1:0] r_max_mul;
    logic [4:0]     w_cands;
    logic           w_conflict;

    // Contention is counted only when results are actually competing (not while flushing)
    always_comb begin
        w_cands    = {w_alu_v, w_mul_head_v, w_mul_in_v, w_div_head_v, w_div_in_v};
        w_conflict = !w_flush && ($countones(w_cands) > 1);
    end

    // Conflict counter and MUL occupancy high-water mark; only reset clears them
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_conflict <= '0;
            r_max_mul  <= '0;
        end else begin
            if (w_conflict)
                r_conflict <= r_conflict + 32'd1;
            if (w_mul_cnt_nxt > r_max_mul)
                r_max_mul <= w_mul_cnt_nxt;
        end
    end

    assign bus.conflict_cycles_o = r_conflict;
    assign bus.max_mul_occ_o     = r_max_mul;
`endif

    assign bus.instruction_o = w_out;
    assign bus.mul_stall_o   = r_mul_stall;
    assign bus.div_stall_o   = r_div_stall;
    assign bus.mul_cnt_o     = r_mul_cnt;
    assign bus.div_cnt_o     = r_div_cnt;

endmodule

// File: tb/tb_scalar_wb_arbiter.sv
// Directed bench for scalar_wb_arbiter with per-source expected-result queues.

module tb_scalar_wb_arbiter;
    import scalar_wb_pkg::*;

    localparam logic [1:0] FU_NONE = 2'd0;
    localparam logic [1:0] FU_ALU  = 2'd1;
    localparam logic [1:0] FU_MUL  = 2'd2;
    localparam logic [1:0] FU_DIV  = 2'd3;

    logic clk_i = 1'b0;
    logic rstn_i;
    always #5 clk_i = ~clk_i;

    scalar_wb_arbiter_if #(.MUL_FIFO_DEPTH(4), .DIV_FIFO_DEPTH(2)) bus();

    scalar_wb_arbiter #(.MUL_FIFO_DEPTH(4), .DIV_FIFO_DEPTH(2), .MUL_INFLIGHT(2)) dut (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    exe_wb_scalar_instr_t q_alu[$], q_mul[$], q_div[$];
    exe_wb_scalar_instr_t idle;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exe_wb_scalar_instr_t mk(input logic [1:0] fu, input logic [31:0] pc,
                                                input logic [31:0] res);
        exe_wb_scalar_instr_t t;
        t            = '0;
        t.valid      = 1'b1;
        t.fu         = fu;
        t.pc         = pc;
        t.result     = res;
        t.rd         = pc[6:2];
        t.rob_id     = pc[5:2];
        t.regfile_we = pc[2];
        return t;
    endfunction

    // Drive one cycle, check the write-back port at the falling edge, return 1ns after the next rise
    task automatic step(input exe_wb_scalar_instr_t a, input exe_wb_scalar_instr_t m,
                        input exe_wb_scalar_instr_t d, input logic fl, input logic [1:0] exp_src);
        exe_wb_scalar_instr_t o, e;
        bus.alu_instr_i = a;
        bus.mul_instr_i = m;
        bus.div_instr_i = d;
        bus.flush_i     = fl;
        if (!fl) begin
            if (a.valid) q_alu.push_back(a);
            if (m.valid) q_mul.push_back(m);
            if (d.valid) q_div.push_back(d);
        end
        @(negedge clk_i);
        o = bus.instruction_o;
        chk("out_valid", 80'(o.valid), 80'(exp_src != FU_NONE));
        if (o.valid) begin
            chk("out_src", 80'(o.fu), 80'(exp_src));
            e = '0;
            case (o.fu)
                FU_ALU:  if (q_alu.size() > 0) e = q_alu.pop_front();
                FU_MUL:  if (q_mul.size() > 0) e = q_mul.pop_front();
                FU_DIV:  if (q_div.size() > 0) e = q_div.pop_front();
                default: e = '0;
            endcase
            chk("out_data", 80'(o), 80'(e));
        end
        if (fl) begin
            q_alu.delete();
            q_mul.delete();
            q_div.delete();
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic post(input logic [2:0] mc, input logic [1:0] dc, input logic ms, input logic ds);
        chk("mul_cnt",   80'(bus.mul_cnt_o),   80'(mc));
        chk("div_cnt",   80'(bus.div_cnt_o),   80'(dc));
        chk("mul_stall", 80'(bus.mul_stall_o), 80'(ms));
        chk("div_stall", 80'(bus.div_stall_o), 80'(ds));
    endtask

    task automatic drive_idle();
        bus.alu_instr_i = '0;
        bus.mul_instr_i = '0;
        bus.div_instr_i = '0;
        bus.flush_i     = 1'b0;
    endtask

    initial begin
        idle = '0;
        rstn_i = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_out", 80'(bus.instruction_o), 80'(0));
        post(3'd0, 2'd0, 1'b0, 1'b0);
`ifdef WB_ARB_STATS_EN
        chk("rst_conflict", 80'(bus.conflict_cycles_o), 80'(0));
        chk("rst_max_mul",  80'(bus.max_mul_occ_o),     80'(0));
`endif
        rstn_i = 1'b1;

        // MUL bypass with empty FIFOs
        step(idle, mk(FU_MUL, 32'h100, 32'h2A), idle, 1'b0, FU_MUL);
        post(3'd0, 2'd0, 1'b0, 1'b0);

        // ALU blocks three MUL results, then they drain in order
        step(mk(FU_ALU, 32'h200, 32'h1), mk(FU_MUL, 32'h10, 32'hA0), idle, 1'b0, FU_ALU);
        post(3'd1, 2'd0, 1'b0, 1'b0);
        step(mk(FU_ALU, 32'h204, 32'h2), mk(FU_MUL, 32'h14, 32'hA1), idle, 1'b0, FU_ALU);
        post(3'd2, 2'd0, 1'b1, 1'b0);
        step(mk(FU_ALU, 32'h208, 32'h3), mk(FU_MUL, 32'h18, 32'hA2), idle, 1'b0, FU_ALU);
        post(3'd3, 2'd0, 1'b1, 1'b0);
        step(idle, idle, idle, 1'b0, FU_MUL);
        post(3'd2, 2'd0, 1'b1, 1'b0);
        step(idle, idle, idle, 1'b0, FU_MUL);
        post(3'd1, 2'd0, 1'b0, 1'b0);
        step(idle, idle, idle, 1'b0, FU_MUL);
        post(3'd0, 2'd0, 1'b0, 1'b0);

        // Simultaneous push and pop with one buffered entry
        step(mk(FU_ALU, 32'h20C, 32'h4), mk(FU_MUL, 32'h20, 32'hB0), idle, 1'b0, FU_ALU);
        post(3'd1, 2'd0, 1'b0, 1'b0);
        step(idle, mk(FU_MUL, 32'h24, 32'hB1), idle, 1'b0, FU_MUL);
        post(3'd1, 2'd0, 1'b0, 1'b0);
        step(idle, idle, idle, 1'b0, FU_MUL);
        post(3'd0, 2'd0, 1'b0, 1'b0);

        // MUL and DIV bypass candidates together: MUL wins, DIV buffered
        step(idle, mk(FU_MUL, 32'h30, 32'hC0), mk(FU_DIV, 32'h40, 32'hD0), 1'b0, FU_MUL);
        post(3'd0, 2'd1, 1'b0, 1'b1);
        step(idle, idle, idle, 1'b0, FU_DIV);
        post(3'd0, 2'd0, 1'b0, 1'b0);
        step(idle, idle, mk(FU_DIV, 32'h44, 32'hD1), 1'b0, FU_DIV);
        post(3'd0, 2'd0, 1'b0, 1'b1);
        step(idle, idle, idle, 1'b0, FU_NONE);
        post(3'd0, 2'd0, 1'b0, 1'b0);

        // Fill MUL FIFO to full (pointers wrap), push/pop at full, then drain
        for (int i = 0; i < 4; i++) begin
            step(mk(FU_ALU, 32'h220 + 32'(4 * i), 32'(i)), mk(FU_MUL, 32'h60 + 32'(4 * i), 32'hE0 + 32'(i)),
                 idle, 1'b0, FU_ALU);
            post(3'(i + 1), 2'd0, (i >= 1), 1'b0);
        end
        step(idle, mk(FU_MUL, 32'h70, 32'hE8), idle, 1'b0, FU_MUL);
        post(3'd4, 2'd0, 1'b1, 1'b0);
        for (int i = 3; i >= 0; i--) begin
            step(idle, idle, idle, 1'b0, FU_MUL);
            post(3'(i), 2'd0, (i >= 2), 1'b0);
        end

        // Flush with buffered MUL and DIV results
        step(mk(FU_ALU, 32'h210, 32'h5), mk(FU_MUL, 32'h50, 32'hF0), mk(FU_DIV, 32'h60, 32'hF8), 1'b0, FU_ALU);
        post(3'd1, 2'd1, 1'b0, 1'b1);
        step(mk(FU_ALU, 32'h214, 32'h6), mk(FU_MUL, 32'h54, 32'hF1), idle, 1'b0, FU_ALU);
        post(3'd2, 2'd1, 1'b1, 1'b1);
        step(mk(FU_ALU, 32'h218, 32'h7), mk(FU_MUL, 32'h58, 32'hF2), idle, 1'b0, FU_ALU);
        post(3'd3, 2'd1, 1'b1, 1'b1);
        step(mk(FU_ALU, 32'h21C, 32'h8), mk(FU_MUL, 32'h5C, 32'hF3), mk(FU_DIV, 32'h64, 32'hF9), 1'b1, FU_NONE);
        post(3'd0, 2'd0, 1'b0, 1'b0);
        step(idle, idle, idle, 1'b0, FU_NONE);
        post(3'd0, 2'd0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a cycle with buffered entries
        step(mk(FU_ALU, 32'h240, 32'h9), mk(FU_MUL, 32'h80, 32'h11), idle, 1'b0, FU_ALU);
        step(mk(FU_ALU, 32'h244, 32'hA), mk(FU_MUL, 32'h84, 32'h12), idle, 1'b0, FU_ALU);
        drive_idle();
        #2;
        rstn_i = 1'b0;
        #1;
        chk("mid_rst_out", 80'(bus.instruction_o), 80'(0));
        post(3'd0, 2'd0, 1'b0, 1'b0);
        q_alu.delete();
        q_mul.delete();
        q_div.delete();
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;

        // Contention sequence from a clean reset: five conflict cycles, MUL peak of 2
        step(mk(FU_ALU, 32'h300, 32'h21), mk(FU_MUL, 32'h90, 32'h31), idle, 1'b0, FU_ALU);
        post(3'd1, 2'd0, 1'b0, 1'b0);
        step(mk(FU_ALU, 32'h304, 32'h22), mk(FU_MUL, 32'h94, 32'h32), idle, 1'b0, FU_ALU);
        post(3'd2, 2'd0, 1'b1, 1'b0);
        step(mk(FU_ALU, 32'h308, 32'h23), idle, idle, 1'b0, FU_ALU);
        post(3'd2, 2'd0, 1'b1, 1'b0);
        step(idle, idle, idle, 1'b0, FU_MUL);
        post(3'd1, 2'd0, 1'b0, 1'b0);
        step(idle, mk(FU_MUL, 32'h98, 32'h33), idle, 1'b0, FU_MUL);
        post(3'd1, 2'd0, 1'b0, 1'b0);
        step(idle, idle, mk(FU_DIV, 32'hA0, 32'h41), 1'b0, FU_MUL);
        post(3'd0, 2'd1, 1'b0, 1'b1);
        step(idle, idle, idle, 1'b0, FU_DIV);
        post(3'd0, 2'd0, 1'b0, 1'b0);
        step(idle, idle, idle, 1'b1, FU_NONE);
        post(3'd0, 2'd0, 1'b0, 1'b0);
`ifdef WB_ARB_STATS_EN
        chk("conflict_cycles", 80'(bus.conflict_cycles_o), 80'(5));
        chk("max_mul_occ",     80'(bus.max_mul_occ_o),     80'(2));
`endif

        chk("alu_q_left", 80'(q_alu.size()), 80'(0));
        chk("mul_q_left", 80'(q_mul.size()), 80'(0));
        chk("div_q_left", 80'(q_div.size()), 80'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
